// File: rtl/multi_edge_sync_barrier_pkg.sv
// Shared edge-mode encodings and the edge-select helper for multi_edge_sync_barrier.
// Consumers import this package to drive the per-channel mode field.
package multi_edge_sync_barrier_pkg;

    typedef enum logic [1:0] {
        EDGE_MODE_OFF  = 2'b00,
        EDGE_MODE_RISE = 2'b01,
        EDGE_MODE_FALL = 2'b10,
        EDGE_MODE_BOTH = 2'b11
    } edge_mode_e;

    function automatic logic edge_select(input logic [1:0] mode, input logic rise,
                                         input logic fall);
        logic sel;
        sel = 1'b0;
        case (edge_mode_e'(mode))
            EDGE_MODE_OFF:  sel = 1'b0;
            EDGE_MODE_RISE: sel = rise;
            EDGE_MODE_FALL: sel = fall;
            EDGE_MODE_BOTH: sel = rise | fall;
            default:        sel = 1'b0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/multi_edge_sync_barrier_channel.sv
// One barrier channel: STAGES-deep synchroniser, optional glitch filter
// (MULTI_EDGE_SYNC_BARRIER_FILTER_EN), edge detector and sticky pending flag.
module multi_edge_sync_barrier_channel
    import multi_edge_sync_barrier_pkg::*;
#(
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       in,
    input  logic [1:0] mode,
    input  logic       clr,
    output logic       pulse,
    output logic       pending,
    output logic       level
);

    if (STAGES < 2) begin : g_stages_check
        $error("multi_edge_sync_barrier: STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_filter_check
        $error("multi_edge_sync_barrier: FILTER_CYCLES must be >= 1");
    end

    logic [STAGES-1:0] sync_q;
    logic              s;
    logic              c;
    logic              prev_q;
    logic              rise;
    logic              fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else if (enable) begin
            sync_q <= {sync_q[STAGES-2:0], in};
        end
    end

    assign s = sync_q[STAGES-1];

`ifdef MULTI_EDGE_SYNC_BARRIER_FILTER_EN
    localparam int CW = $clog2(FILTER_CYCLES + 1);

    logic [CW-1:0] cnt_q;
    logic          c_q;

    // c only follows s once s has disagreed with it for FILTER_CYCLES enabled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            c_q   <= 1'b0;
        end else if (enable) begin
            if (s == c_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_CYCLES - 1)) begin
                c_q   <= s;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign c = c_q;
`else
    assign c = s;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q <= 1'b0;
        end else if (enable) begin
            prev_q <= c;
        end
    end

    assign rise  = c & ~prev_q;
    assign fall  = ~c & prev_q;
    assign pulse = enable & edge_select(mode, rise, fall);
    assign level = c;

    // A pulse in the same cycle as clr keeps the flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (enable) begin
            if (pulse) begin
                pending <= 1'b1;
            end else if (clr) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_edge_sync_barrier.sv
// Multi-channel clock-domain barrier: CHANNELS independent sync/edge/pending channels.
// Optional glitch filter enabled by defining MULTI_EDGE_SYNC_BARRIER_FILTER_EN.
module multi_edge_sync_barrier
    import multi_edge_sync_barrier_pkg::*;
#(
    parameter int CHANNELS      = 1,
    parameter int STAGES        = 2,
    parameter int FILTER_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [CHANNELS-1:0]   in,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   pending,
    output logic [CHANNELS-1:0]   level
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        multi_edge_sync_barrier_channel #(
            .STAGES       (STAGES),
            .FILTER_CYCLES(FILTER_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .enable (enable),
            .in     (in[k]),
            .mode   (mode[2*k+1 -: 2]),
            .clr    (clr[k]),
            .pulse  (pulse[k]),
            .pending(pending[k]),
            .level  (level[k])
        );
    end

endmodule
